dmem_arbiter: RTL
=================

// Module: dmem_arbiter
// PURPOSE
//  Two-requester arbiter for the single-port data memory used by the MEM stage.
//  Port 0 is the pipeline MEM stage; port 1 is the loader/debug master.
//  Grants one access per cycle, drives the memory port and routes each read response back to its issuer.
//  Stalls the pipeline while port 0 is denied, and enforces a starvation bound on port 1.
// PARAMETERS
//  AW         32  address width (byte address; memory is word-indexed by addr>>2)
//  DW         32  data width
//  STARVE_MAX 4   consecutive denied cycles for port 1 before it is forced to win
// PORTS
//  clk         in   1   rising-edge clock
//  reset       in   1   asynchronous, active-high reset
//  p0_req      in   1   MEM-stage access request (held until granted)
//  p0_we       in   1   1 = write, 0 = read
//  p0_addr     in   AW  byte address
//  p0_wdata    in   DW  write data
//  p0_gnt      out  1   access accepted this cycle (combinational)
//  p0_rvalid   out  1   p0_rdata valid (registered)
//  p0_rdata    out  DW  read data
//  p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_rvalid, p1_rdata  same as port 0, for port 1
//  cpu_stall   out  1   p0_req & ~p0_gnt (combinational)
//  misalign    out  1   pulse: a granted access had addr[1:0]!=0 (registered)
//  mem_we      out  1   memory write enable
//  mem_re      out  1   memory read enable
//  mem_addr    out  AW  memory byte address
//  mem_wdata   out  DW  memory write data
//  mem_rdata   in   DW  memory read data, valid 1 cycle after mem_re
// BEHAVIOUR
//  - Reset values: all gnt/rvalid/stall/misalign/mem_we/mem_re = 0; rdata, mem_addr, mem_wdata = 0;
//    starve_cnt = 0; resp_owner = NONE.
//  - Grant, decided each cycle:
//    * Port 0 wins by default.
//    * Port 1 wins if p0_req=0, or if starve_cnt==STARVE_MAX.
//    * At most one grant per cycle.
//  - starve_cnt:
//    * Increments (saturating at STARVE_MAX) when p1_req & ~p1_gnt.
//    * Clears when p1_gnt=1 or p1_req=0.
//  - The granted port's we/addr/wdata drive mem_* in the same cycle (combinational mux).
//    mem_we = gnt & we; mem_re = gnt & ~we.
//  - Misaligned access (addr[1:0]!=0):
//    * gnt is still given, but mem_we and mem_re are forced to 0.
//    * misalign pulses the next cycle.
//    * A read gets rvalid with rdata=0 so the requester never hangs.
//  - Response FSM (resp_owner register): NONE / P0 / P1.
//    * On a granted read it loads that port; otherwise it goes to NONE.
//    * In the next cycle, the rvalid of resp_owner goes high for exactly 1 cycle and rdata captures mem_rdata.
//    * The other port's rdata holds its last value.
//  - Read latency: 1 cycle from gnt to rvalid. Back-to-back reads from alternating ports give one rvalid per cycle.
//  - Write then read of the same address on consecutive cycles: the read returns the new data (memory is written at the grant edge).
//  - cpu_stall is combinational so the pipeline freezes in the same cycle. The pipeline holds p0_* stable while stalled.
//  - Reset mid-operation: a pending rvalid is dropped, starve_cnt clears, and no memory strobe issues while reset=1.
//  - Requests with req=0 are ignored regardless of we/addr.
// TESTING
//  1. Reset, then p0 write 0xDEADBEEF @0x10, then p0 read @0x10
//     -> p0_gnt both cycles; p0_rvalid 1 cycle after the read; p0_rdata=0xDEADBEEF.
//  2. p0_req and p1_req held high continuously (reads)
//     -> p1 is denied 4 cycles, granted on the 5th, then denied again.
//     -> cpu_stall=1 only in the p1-grant cycles.
//  3. p0_req=0, p1 reads @0x20 (holding 0x12345678)
//     -> p1_gnt same cycle; p1_rvalid next cycle with 0x12345678; p0_rvalid stays 0.
//  4. p0 read @0x13 (misaligned)
//     -> p0_gnt=1; mem_re=0; next cycle misalign=1, p0_rvalid=1, p0_rdata=0.
//  5. p1 read granted, reset asserted before the next edge
//     -> p1_rvalid never rises; all outputs 0; starve_cnt=0 after release.
//  6. Alternating grants: p1 write @0x40=0xA5A5A5A5, then p0 read @0x40
//     -> p0_rdata=0xA5A5A5A5 with 1-cycle latency, no stall.

Source files
------------

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port data memory arbiter with starvation bound and read response routing
module dmem_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_gnt,
  output logic          p0_rvalid,
  output logic [DW-1:0] p0_rdata,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_gnt,
  output logic          p1_rvalid,
  output logic [DW-1:0] p1_rdata,
  output logic          cpu_stall,
  output logic          misalign,
  output logic          mem_we,
  output logic          mem_re,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_P0   = 2'd1;
  localparam logic [1:0] OWN_P1   = 2'd2;

  logic [SW-1:0] starve_cnt;
  logic [1:0]    resp_owner;
  logic          resp_zero;
  logic [DW-1:0] held0;
  logic [DW-1:0] held1;

  logic          starve_max;
  logic          p1_win;
  logic          any_gnt;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          aligned;
  logic [DW-1:0] resp_data;

  assign starve_max = (starve_cnt == SW'(STARVE_MAX));
  assign p1_win     = p1_req & (~p0_req | starve_max);

  // Grants are suppressed during reset so no memory strobe can escape.
  assign p1_gnt    = ~reset & p1_win;
  assign p0_gnt    = ~reset & p0_req & ~p1_win;
  assign any_gnt   = p0_gnt | p1_gnt;
  assign cpu_stall = ~reset & p0_req & ~p0_gnt;

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    if (p1_gnt) begin
      sel_we    = p1_we;
      sel_addr  = p1_addr;
      sel_wdata = p1_wdata;
    end else if (p0_gnt) begin
      sel_we    = p0_we;
      sel_addr  = p0_addr;
      sel_wdata = p0_wdata;
    end
  end

  assign aligned   = (sel_addr[1:0] == 2'b00);
  assign mem_we    = any_gnt & sel_we & aligned;
  assign mem_re    = any_gnt & ~sel_we & aligned;
  assign mem_addr  = sel_addr;
  assign mem_wdata = sel_wdata;

  // A misaligned read still completes, returning zero instead of memory data.
  assign resp_data = resp_zero ? '0 : mem_rdata;
  assign p0_rvalid = (resp_owner == OWN_P0);
  assign p1_rvalid = (resp_owner == OWN_P1);
  assign p0_rdata  = p0_rvalid ? resp_data : held0;
  assign p1_rdata  = p1_rvalid ? resp_data : held1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
      resp_owner <= OWN_NONE;
      resp_zero  <= 1'b0;
      misalign   <= 1'b0;
      held0      <= '0;
      held1      <= '0;
    end else begin
      if (p1_req & ~p1_gnt)
        starve_cnt <= starve_max ? starve_cnt : starve_cnt + 1'b1;
      else
        starve_cnt <= '0;

      misalign  <= any_gnt & ~aligned;
      resp_zero <= ~aligned;

      if (any_gnt & ~sel_we)
        resp_owner <= p1_gnt ? OWN_P1 : OWN_P0;
      else
        resp_owner <= OWN_NONE;

      if (resp_owner == OWN_P0) held0 <= resp_data;
      if (resp_owner == OWN_P1) held1 <= resp_data;
    end
  end

endmodule
